// File: rtl/eth_cmd_decoder.sv
// Command-frame decoder for the MAC RX stream: filters on board MAC and ethertype,
// then commits one 32-bit register write per frame into the run-control register file.
module eth_cmd_decoder #(
  parameter logic [15:0] ETHERTYPE          = 16'h88B5,
  parameter logic [47:0] DEFAULT_D_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] DEFAULT_S_MAC      = 48'h0002_0304_0506,
  parameter logic [11:0] DEFAULT_COUNTER_TH = 12'd256,
  parameter logic [15:0] DEFAULT_IDLE_TH    = 16'd4096,
  parameter logic [9:0]  DEFAULT_TRIG_WIDTH = 10'd40,
  parameter int          RST_PULSE_LEN      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_axis_fifo_tdata,
  input  logic        rx_axis_fifo_tvalid,
  input  logic        rx_axis_fifo_tlast,
  output logic        rx_axis_fifo_tready,
  output logic        soft_reset,
  output logic        tds_mode,
  output logic        debug_enable,
  output logic        enable_trigger,
  output logic [3:0]  channel_enable,
  output logic [47:0] d_mac_add,
  output logic [47:0] s_mac_add,
  output logic [11:0] counter_th,
  output logic [15:0] idle_counter_number_th,
  output logic [9:0]  trigger_width,
  output logic        cmd_done,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int         CNT_W    = $clog2(RST_PULSE_LEN + 1);
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ADDR_MAX = 8'h08;

  typedef enum logic [1:0] {RECV = 2'd0, DROP = 2'd1, COMMIT = 2'd2} state_t;

  state_t           state_r;
  logic [5:0]       idx_r;
  logic             ucast_r;
  logic             bcast_r;
  logic             bad_r;
  logic [7:0]       addr_r;
  logic [31:0]      data_r;
  logic [CNT_W-1:0] rst_cnt_r;

  logic             take_s;
  logic             ucast_s;
  logic             bcast_s;
  logic             hdr_fail_s;
  logic             bad_s;
  logic             commit_ok_s;
  logic             pulse_start_s;
  logic [31:0]      word_s;

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    case (idx)
      6'd0:    mac_byte = mac[47:40];
      6'd1:    mac_byte = mac[39:32];
      6'd2:    mac_byte = mac[31:24];
      6'd3:    mac_byte = mac[23:16];
      6'd4:    mac_byte = mac[15:8];
      6'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  function automatic logic addr_in_map(input logic [7:0] addr);
    addr_in_map = (addr <= ADDR_MAX);
  endfunction

  // Per-byte header checks and data-word assembly for the byte on the bus
  always_comb begin
    take_s     = rx_axis_fifo_tvalid & rx_axis_fifo_tready;
    ucast_s    = ucast_r;
    bcast_s    = bcast_r;
    hdr_fail_s = 1'b0;
    bad_s      = bad_r;
    word_s     = data_r;
    if (idx_r < 6'd6) begin
      // unicast and broadcast are tracked separately so a mixed MAC is rejected
      ucast_s    = ucast_r & (rx_axis_fifo_tdata == mac_byte(s_mac_add, idx_r));
      bcast_s    = bcast_r & (rx_axis_fifo_tdata == 8'hFF);
      hdr_fail_s = ~(ucast_s | bcast_s);
    end else if (idx_r == 6'd12) begin
      hdr_fail_s = (rx_axis_fifo_tdata != ETHERTYPE[15:8]);
    end else if (idx_r == 6'd13) begin
      hdr_fail_s = (rx_axis_fifo_tdata != ETHERTYPE[7:0]);
    end else if (idx_r == 6'd14) begin
      bad_s = bad_r | (rx_axis_fifo_tdata != OP_WRITE);
    end else if (idx_r == 6'd15) begin
      bad_s = bad_r | ~addr_in_map(rx_axis_fifo_tdata);
    end else if ((idx_r >= 6'd16) && (idx_r <= 6'd19)) begin
      word_s = {data_r[23:0], rx_axis_fifo_tdata};
    end else begin
      word_s = data_r;
    end
    commit_ok_s   = (idx_r >= 6'd19) & ~bad_s;
    pulse_start_s = take_s & (state_r != DROP) & ~hdr_fail_s & rx_axis_fifo_tlast &
                    commit_ok_s & (addr_r == 8'h00) & word_s[0];
  end

  // Frame parser FSM, register file and frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r                <= RECV;
      idx_r                  <= 6'd0;
      ucast_r                <= 1'b1;
      bcast_r                <= 1'b1;
      bad_r                  <= 1'b0;
      addr_r                 <= 8'h00;
      data_r                 <= 32'h0000_0000;
      rx_axis_fifo_tready    <= 1'b0;
      tds_mode               <= 1'b0;
      debug_enable           <= 1'b0;
      enable_trigger         <= 1'b0;
      channel_enable         <= 4'h0;
      d_mac_add              <= DEFAULT_D_MAC;
      s_mac_add              <= DEFAULT_S_MAC;
      counter_th             <= DEFAULT_COUNTER_TH;
      idle_counter_number_th <= DEFAULT_IDLE_TH;
      trigger_width          <= DEFAULT_TRIG_WIDTH;
      cmd_done               <= 1'b0;
      frames_ok              <= 16'd0;
      frames_bad             <= 16'd0;
    end else begin
      rx_axis_fifo_tready <= 1'b1;
      cmd_done            <= 1'b0;
      case (state_r)
        RECV, COMMIT: begin
          // COMMIT lasts one cycle; a byte taken here is byte 0 of the next frame
          if (take_s) begin
            idx_r   <= (idx_r == 6'd63) ? 6'd63 : idx_r + 6'd1;
            ucast_r <= ucast_s;
            bcast_r <= bcast_s;
            bad_r   <= bad_s;
            data_r  <= word_s;
            if (idx_r == 6'd15) begin
              addr_r <= rx_axis_fifo_tdata;
            end else begin
              addr_r <= addr_r;
            end
            if (hdr_fail_s) begin
              if (rx_axis_fifo_tlast) begin
                state_r <= RECV;
                idx_r   <= 6'd0;
                ucast_r <= 1'b1;
                bcast_r <= 1'b1;
                bad_r   <= 1'b0;
              end else begin
                state_r <= DROP;
              end
            end else if (rx_axis_fifo_tlast) begin
              state_r <= COMMIT;
              idx_r   <= 6'd0;
              ucast_r <= 1'b1;
              bcast_r <= 1'b1;
              bad_r   <= 1'b0;
              if (commit_ok_s) begin
                cmd_done  <= 1'b1;
                frames_ok <= frames_ok + 16'd1;
                case (addr_r)
                  8'h00: begin
                    tds_mode       <= word_s[1];
                    debug_enable   <= word_s[2];
                    enable_trigger <= word_s[3];
                  end
                  8'h01:   channel_enable          <= word_s[3:0];
                  8'h02:   d_mac_add[31:0]         <= word_s;
                  8'h03:   d_mac_add[47:32]        <= word_s[15:0];
                  8'h04:   s_mac_add[31:0]         <= word_s;
                  8'h05:   s_mac_add[47:32]        <= word_s[15:0];
                  8'h06:   counter_th              <= word_s[11:0];
                  8'h07:   idle_counter_number_th  <= word_s[15:0];
                  8'h08:   trigger_width           <= word_s[9:0];
                  default: cmd_done                <= 1'b1;
                endcase
              end else begin
                frames_bad <= frames_bad + 16'd1;
              end
            end else begin
              state_r <= RECV;
            end
          end else begin
            state_r <= RECV;
          end
        end
        DROP: begin
          if (take_s && rx_axis_fifo_tlast) begin
            state_r <= RECV;
            idx_r   <= 6'd0;
            ucast_r <= 1'b1;
            bcast_r <= 1'b1;
            bad_r   <= 1'b0;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r <= RECV;
          idx_r   <= 6'd0;
          ucast_r <= 1'b1;
          bcast_r <= 1'b1;
          bad_r   <= 1'b0;
        end
      endcase
    end
  end

  // Soft-reset pulse: held during reset, restarted by every ctrl write with bit0 set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      soft_reset <= 1'b1;
      rst_cnt_r  <= {CNT_W{1'b0}};
    end else if (pulse_start_s) begin
      soft_reset <= 1'b1;
      rst_cnt_r  <= CNT_W'(RST_PULSE_LEN - 1);
    end else if (rst_cnt_r != {CNT_W{1'b0}}) begin
      soft_reset <= 1'b1;
      rst_cnt_r  <= rst_cnt_r - CNT_W'(1);
    end else begin
      soft_reset <= 1'b0;
      rst_cnt_r  <= rst_cnt_r;
    end
  end

endmodule

// File: tb/tb_eth_cmd_decoder.sv
// Directed bench for eth_cmd_decoder: commits are checked against a scoreboard of
// expected register snapshots; a second instance with a longer pulse checks restart.
module tb_eth_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;

  logic        rx_axis_fifo_tready, soft_reset, tds_mode, debug_enable, enable_trigger, cmd_done;
  logic [3:0]  channel_enable;
  logic [47:0] d_mac_add, s_mac_add;
  logic [11:0] counter_th;
  logic [15:0] idle_counter_number_th, frames_ok, frames_bad;
  logic [9:0]  trigger_width;

  logic        b_tready, b_soft_reset, b_tds_mode, b_debug_enable, b_enable_trigger, b_cmd_done;
  logic [3:0]  b_channel_enable;
  logic [47:0] b_d_mac_add, b_s_mac_add;
  logic [11:0] b_counter_th;
  logic [15:0] b_idle_th, b_frames_ok, b_frames_bad;
  logic [9:0]  b_trigger_width;

  localparam logic [47:0] BOARD = 48'h0002_0304_0506;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ET    = 16'h88B5;

  typedef struct packed {
    logic        tds, dbg, trig;
    logic [3:0]  chan;
    logic [47:0] dmac, smac;
    logic [11:0] cth;
    logic [15:0] idle;
    logic [9:0]  tw;
    logic [15:0] ok;
  } snap_t;

  snap_t      m;
  snap_t      exp_q[$];
  logic [7:0] frm[$];
  int         vectors = 0;
  int         miss = 0;
  int         run1 = 0, run2 = 0;
  int         runs1[$], runs2[$];

  always #5 clk = ~clk;

  eth_cmd_decoder dut (
    .clk(clk), .reset(reset),
    .rx_axis_fifo_tdata(tdata), .rx_axis_fifo_tvalid(tvalid), .rx_axis_fifo_tlast(tlast),
    .rx_axis_fifo_tready(rx_axis_fifo_tready), .soft_reset(soft_reset), .tds_mode(tds_mode),
    .debug_enable(debug_enable), .enable_trigger(enable_trigger), .channel_enable(channel_enable),
    .d_mac_add(d_mac_add), .s_mac_add(s_mac_add), .counter_th(counter_th),
    .idle_counter_number_th(idle_counter_number_th), .trigger_width(trigger_width),
    .cmd_done(cmd_done), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  eth_cmd_decoder #(.RST_PULSE_LEN(32)) dut_long (
    .clk(clk), .reset(reset),
    .rx_axis_fifo_tdata(tdata), .rx_axis_fifo_tvalid(tvalid), .rx_axis_fifo_tlast(tlast),
    .rx_axis_fifo_tready(b_tready), .soft_reset(b_soft_reset), .tds_mode(b_tds_mode),
    .debug_enable(b_debug_enable), .enable_trigger(b_enable_trigger), .channel_enable(b_channel_enable),
    .d_mac_add(b_d_mac_add), .s_mac_add(b_s_mac_add), .counter_th(b_counter_th),
    .idle_counter_number_th(b_idle_th), .trigger_width(b_trigger_width),
    .cmd_done(b_cmd_done), .frames_ok(b_frames_ok), .frames_bad(b_frames_bad)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_defaults();
    m = '{tds: 1'b0, dbg: 1'b0, trig: 1'b0, chan: 4'h0, dmac: BCAST, smac: BOARD,
          cth: 12'd256, idle: 16'd4096, tw: 10'd40, ok: 16'd0};
  endtask

  task automatic expect_write(input logic [7:0] addr, input logic [31:0] d);
    case (addr)
      8'h00: begin m.tds = d[1]; m.dbg = d[2]; m.trig = d[3]; end
      8'h01: m.chan = d[3:0];
      8'h02: m.dmac[31:0] = d;
      8'h03: m.dmac[47:32] = d[15:0];
      8'h04: m.smac[31:0] = d;
      8'h05: m.smac[47:32] = d[15:0];
      8'h06: m.cth = d[11:0];
      8'h07: m.idle = d[15:0];
      8'h08: m.tw = d[9:0];
      default: m.ok = m.ok;
    endcase
    m.ok = m.ok + 16'd1;
    exp_q.push_back(m);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                       input logic [7:0] addr, input logic [31:0] d, input int len);
    logic [47:0] src;
    src = 48'h1234_5678_9ABC;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    frm.push_back(op);
    frm.push_back(addr);
    for (int i = 0; i < 4; i++) frm.push_back(d[31-8*i -: 8]);
    while (frm.size() > len) void'(frm.pop_back());
    while (frm.size() < len) frm.push_back(8'h00);
  endtask

  // Drives bytes lo..hi, starting and ending on a falling edge, honouring tready
  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      tdata  = frm[i];
      tvalid = 1'b1;
      tlast  = (i == frm.size() - 1);
      while (!acc && guard < 20) begin
        acc = rx_axis_fifo_tready;
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      if (!acc) chk("tready_wait", 64'(acc), 64'd1);
    end
  endtask

  task automatic send_all();
    send_range(0, frm.size() - 1);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Commit monitor: every cmd_done must match the oldest expected snapshot
  always @(negedge clk) begin
    snap_t cur, want;
    if (!reset && cmd_done) begin
      cur = {tds_mode, debug_enable, enable_trigger, channel_enable, d_mac_add, s_mac_add,
             counter_th, idle_counter_number_th, trigger_width, frames_ok};
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd_done", 64'(cmd_done), 64'd0);
      end else begin
        want = exp_q.pop_front();
        vectors++;
        assert (cur === want) else begin
          miss++;
          $error("FAIL commit_snapshot observed=%h expected=%h", cur, want);
        end
      end
    end
  end

  // Soft-reset run-length recorders for both instances
  always @(negedge clk) begin
    if (soft_reset) run1++;
    else if (run1 != 0) begin runs1.push_back(run1); run1 = 0; end
    if (b_soft_reset) run2++;
    else if (run2 != 0) begin runs2.push_back(run2); run2 = 0; end
  end

  initial begin
    reset = 1'b1; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0;
    model_defaults();
    repeat (3) @(negedge clk);
    chk("rst_tready", 64'(rx_axis_fifo_tready), 64'd0);
    chk("rst_soft_reset", 64'(soft_reset), 64'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("def_tready", 64'(rx_axis_fifo_tready), 64'd1);
    chk("def_soft_reset", 64'(soft_reset), 64'd0);
    chk("def_dmac", 64'(d_mac_add), 64'(BCAST));
    chk("def_smac", 64'(s_mac_add), 64'(BOARD));
    chk("def_cth", 64'(counter_th), 64'd256);
    chk("def_idle", 64'(idle_counter_number_th), 64'd4096);
    chk("def_tw", 64'(trigger_width), 64'd40);
    chk("def_ctrl", 64'({tds_mode, debug_enable, enable_trigger, channel_enable}), 64'd0);
    chk("def_counts", 64'({frames_ok, frames_bad, cmd_done}), 64'd0);
    runs1.delete(); runs2.delete();

    // unicast write to channel_enable
    build(BOARD, ET, 8'h57, 8'h01, 32'h0000_000A, 20);
    expect_write(8'h01, 32'h0000_000A);
    send_all(); idle(4);
    chk("uni_chan", 64'(channel_enable), 64'hA);
    chk("uni_ok", 64'(frames_ok), 64'd1);
    chk("uni_q", 64'(exp_q.size()), 64'd0);

    // foreign destination is dropped silently
    build(48'h0200_0000_0099, ET, 8'h57, 8'h01, 32'h0000_0005, 20);
    send_all(); idle(4);
    chk("foreign_chan", 64'(channel_enable), 64'hA);
    chk("foreign_counts", 64'({frames_ok, frames_bad}), 64'({16'd1, 16'd0}));

    // broadcast, padded frames (second one past index saturation)
    build(BCAST, ET, 8'h57, 8'h06, 32'h0000_0FFF, 60);
    expect_write(8'h06, 32'h0000_0FFF);
    send_all();
    build(BCAST, ET, 8'h57, 8'h03, 32'h0000_1234, 70);
    expect_write(8'h03, 32'h0000_1234);
    send_all(); idle(4);
    chk("bc_cth", 64'(counter_th), 64'hFFF);
    chk("bc_dmac", 64'(d_mac_add), 64'h1234_FFFF_FFFF);
    chk("bc_ok", 64'(frames_ok), 64'd3);

    // short frame and unmapped address count as bad
    build(BOARD, ET, 8'h57, 8'h01, 32'h0000_0005, 18);
    send_all(); idle(2);
    chk("short_bad", 64'(frames_bad), 64'd1);
    build(BOARD, ET, 8'h57, 8'h20, 32'h0000_0005, 20);
    send_all(); idle(4);
    chk("addr_bad", 64'(frames_bad), 64'd2);
    chk("bad_no_write", 64'({channel_enable, frames_ok}), 64'({4'hA, 16'd3}));

    // back-to-back ctrl writes with soft-reset request
    build(BOARD, ET, 8'h57, 8'h00, 32'h0000_0003, 20);
    expect_write(8'h00, 32'h0000_0003);
    send_all();
    build(BOARD, ET, 8'h57, 8'h00, 32'h0000_000D, 20);
    expect_write(8'h00, 32'h0000_000D);
    send_all(); idle(70);
    chk("pulse_n", 64'(runs1.size()), 64'd2);
    if (runs1.size() == 2) begin
      chk("pulse_first_len", 64'(runs1[0]), 64'd16);
      chk("pulse_second_len", 64'(runs1[1]), 64'd16);
    end
    chk("pulse_long_n", 64'(runs2.size()), 64'd1);
    if (runs2.size() == 1) chk("pulse_restart_len", 64'(runs2[0]), 64'd52);
    chk("ctrl_bits", 64'({tds_mode, debug_enable, enable_trigger}), 64'b011);
    chk("ctrl_q", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a frame, then the tail and two valid frames back-to-back
    build(BOARD, ET, 8'h57, 8'h01, 32'h0000_0005, 20);
    send_range(0, 9);
    tdata = frm[10]; tvalid = 1'b1; tlast = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_tready", 64'(rx_axis_fifo_tready), 64'd0);
    chk("mid_rst_regs", 64'({channel_enable, counter_th, frames_ok}), 64'({4'h0, 12'd256, 16'd0}));
    reset = 1'b0;
    model_defaults();
    send_range(10, 19);
    build(BOARD, ET, 8'h57, 8'h08, 32'h0000_03FF, 20);
    expect_write(8'h08, 32'h0000_03FF);
    send_all();
    build(BCAST, ET, 8'h57, 8'h07, 32'h0000_BEEF, 20);
    expect_write(8'h07, 32'h0000_BEEF);
    send_all(); idle(4);
    chk("post_rst_counts", 64'({frames_ok, frames_bad}), 64'({16'd2, 16'd0}));
    chk("post_rst_tw", 64'(trigger_width), 64'h3FF);
    chk("post_rst_idle", 64'(idle_counter_number_th), 64'hBEEF);
    chk("post_rst_dmac", 64'(d_mac_add), 64'(BCAST));
    chk("post_rst_q", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
